// File: rtl/mp_tpcs_usb4_tx_rate_seq.sv
// mp_tpcs_usb4_tx_rate_seq
// USB4 PIPE Tx rate-change sequencer (single lane). When the MAC asks for a
// new rate it gates Tx data, waits for the MAC to idle the lane, hands the new
// rate to the PMA and waits for its ack. It then lets the lane settle before
// re-enabling data and pulsing pipe_phystatus. An ack that never arrives is
// reported through a sticky error flag, and the change is retried.
//
// Parameters
//   SETTLE_CYC  : pclk cycles from PMA ack until Tx data is re-enabled (1..255)
//   ACK_TIMEOUT : max pclk cycles spent waiting for pma_rate_ack (1..4095)
// Ports
//   pclk, pclk_rst_n   : clock, asynchronous active-low reset
//   mac_rate[1:0]      : requested rate (00 Gen2, 01 Gen3; 1x treated as 00)
//   mac_tx_elec_idle   : MAC has put the lane into electrical idle
//   mac_tx_data_valid  : MAC TxDataValid
//   pma_rate_ack       : level ack from the PMA that the rate change is done
//   dp_pipe_rate[1:0]  : rate currently applied to the Tx datapath
//   dp_tx_data_valid   : gated TxDataValid to the datapath
//   pma_rate_req       : rate-change request to the PMA
//   pma_rate[1:0]      : target rate presented to the PMA
//   pipe_phystatus     : one-cycle pulse on completion or abort of a change
//   rate_chg_err       : sticky ack-timeout flag, cleared only by reset
module mp_tpcs_usb4_tx_rate_seq #(
  parameter int SETTLE_CYC  = 16,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic       pclk,
  input  logic       pclk_rst_n,
  input  logic [1:0] mac_rate,
  input  logic       mac_tx_elec_idle,
  input  logic       mac_tx_data_valid,
  input  logic       pma_rate_ack,
  output logic [1:0] dp_pipe_rate,
  output logic       dp_tx_data_valid,
  output logic       pma_rate_req,
  output logic [1:0] pma_rate,
  output logic       pipe_phystatus,
  output logic       rate_chg_err
);

  typedef enum logic [2:0] {
    ST_ACTIVE,
    ST_QUIESCE,
    ST_REQ,
    ST_WAIT_ACK,
    ST_SETTLE
  } state_t;

  // The counter is compared against its last value rather than the limit
  // itself, so WAIT_ACK lasts exactly ACK_TIMEOUT cycles and SETTLE exactly
  // SETTLE_CYC cycles.
  localparam logic [11:0] ACK_LAST    = 12'(ACK_TIMEOUT - 1);
  localparam logic [11:0] SETTLE_LAST = 12'(SETTLE_CYC - 1);

  state_t      state, state_nxt;
  logic [11:0] cnt, cnt_nxt;
  logic [1:0]  dp_rate_nxt, pma_rate_nxt;
  logic        req_nxt, phy_nxt, err_nxt;
  logic        run_en;
  logic [1:0]  target;
  logic        rate_mismatch;

  // Reserved encodings fall back to Gen2.
  assign target        = (mac_rate == 2'b01) ? 2'b01 : 2'b00;
  assign rate_mismatch = (target != dp_pipe_rate);

  // Data is cut in the same cycle a mismatch appears, before the FSM reacts.
  assign dp_tx_data_valid = mac_tx_data_valid && (state == ST_ACTIVE) && !rate_mismatch;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    dp_rate_nxt  = dp_pipe_rate;
    pma_rate_nxt = pma_rate;
    req_nxt      = 1'b0;
    phy_nxt      = 1'b0;
    err_nxt      = rate_chg_err;
    case (state)
      ST_ACTIVE: begin
        // run_en holds the FSM for the first edge after reset release.
        if (run_en && rate_mismatch) state_nxt = ST_QUIESCE;
      end
      ST_QUIESCE: begin
        if (mac_tx_elec_idle) begin
          pma_rate_nxt = target;
          state_nxt    = ST_REQ;
        end
      end
      ST_REQ: begin
        cnt_nxt   = '0;
        req_nxt   = 1'b1;
        state_nxt = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        // Ack is tested first so it wins over a timeout in the same cycle.
        if (pma_rate_ack) begin
          dp_rate_nxt = pma_rate;
          cnt_nxt     = '0;
          state_nxt   = ST_SETTLE;
        end else if (cnt == ACK_LAST) begin
          err_nxt   = 1'b1;
          phy_nxt   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_ACTIVE;
        end else begin
          cnt_nxt = cnt + 12'd1;
          req_nxt = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          phy_nxt   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_ACTIVE;
        end else begin
          cnt_nxt = cnt + 12'd1;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_ACTIVE;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge pclk_rst_n) begin
    if (!pclk_rst_n) begin
      state          <= ST_ACTIVE;
      cnt            <= '0;
      dp_pipe_rate   <= 2'b00;
      pma_rate       <= 2'b00;
      pma_rate_req   <= 1'b0;
      pipe_phystatus <= 1'b0;
      rate_chg_err   <= 1'b0;
      run_en         <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      dp_pipe_rate   <= dp_rate_nxt;
      pma_rate       <= pma_rate_nxt;
      pma_rate_req   <= req_nxt;
      pipe_phystatus <= phy_nxt;
      rate_chg_err   <= err_nxt;
      run_en         <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mp_tpcs_usb4_tx_rate_seq.sv
// tb_mp_tpcs_usb4_tx_rate_seq
// Randomized bench for the USB4 Tx rate-change sequencer. Stimulus tasks push
// expected request-rise and phystatus events (cycle, rate, error flag) into
// queues; a negedge monitor pops and compares whenever the DUT shows them.
module tb_mp_tpcs_usb4_tx_rate_seq;

  localparam int SETTLE = 6;
  localparam int ATO    = 8;

  logic       pclk = 1'b0;
  logic       pclk_rst_n = 1'b0;
  logic [1:0] mac_rate = 2'b00;
  logic       mac_tx_elec_idle = 1'b0;
  logic       mac_tx_data_valid = 1'b1;
  logic       pma_rate_ack = 1'b0;
  logic [1:0] dp_pipe_rate;
  logic       dp_tx_data_valid;
  logic       pma_rate_req;
  logic [1:0] pma_rate;
  logic       pipe_phystatus;
  logic       rate_chg_err;

  mp_tpcs_usb4_tx_rate_seq #(.SETTLE_CYC(SETTLE), .ACK_TIMEOUT(ATO)) dut (
    .pclk              (pclk),
    .pclk_rst_n        (pclk_rst_n),
    .mac_rate          (mac_rate),
    .mac_tx_elec_idle  (mac_tx_elec_idle),
    .mac_tx_data_valid (mac_tx_data_valid),
    .pma_rate_ack      (pma_rate_ack),
    .dp_pipe_rate      (dp_pipe_rate),
    .dp_tx_data_valid  (dp_tx_data_valid),
    .pma_rate_req      (pma_rate_req),
    .pma_rate          (pma_rate),
    .pipe_phystatus    (pipe_phystatus),
    .rate_chg_err      (rate_chg_err)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [1:0] rate; } req_t;
  typedef struct { int cyc; logic [1:0] rate; logic err; } done_t;
  req_t  req_q[$];
  done_t done_q[$];

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference state: rate the link runs at and the sticky error flag.
  logic [1:0] model_rate = 2'b00;
  logic       model_err  = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vec_cnt++;
    if (actual !== expected) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic pushReq(input int c, input logic [1:0] r);
    req_t e;
    e.cyc  = c;
    e.rate = r;
    req_q.push_back(e);
  endtask

  task automatic pushDone(input int c, input logic [1:0] r, input logic e_err);
    done_t e;
    e.cyc  = c;
    e.rate = r;
    e.err  = e_err;
    done_q.push_back(e);
  endtask

  // Monitor: compares every request rise and every phystatus pulse.
  logic req_prev = 1'b0;
  always @(negedge pclk) begin
    req_t  r;
    done_t d;
    if (pma_rate_req && !req_prev) begin
      if (req_q.size() == 0) checkOutput("unexpected_req", pma_rate_req, 0);
      else begin
        r = req_q.pop_front();
        checkOutput("req_cycle", cyc, r.cyc);
        checkOutput("req_pma_rate", pma_rate, r.rate);
      end
    end
    req_prev = pma_rate_req;
    if (pipe_phystatus) begin
      if (done_q.size() == 0) checkOutput("unexpected_phystatus", pipe_phystatus, 0);
      else begin
        d = done_q.pop_front();
        checkOutput("phy_cycle", cyc, d.cyc);
        checkOutput("phy_dp_rate", dp_pipe_rate, d.rate);
        checkOutput("phy_err", rate_chg_err, d.err);
      end
    end
  end

  task automatic waitReq(output int r, output bit ok);
    ok = 1'b0;
    r  = 0;
    for (int i = 0; i < 60; i++) begin
      if (pma_rate_req) begin
        r  = cyc;
        ok = 1'b1;
        return;
      end
      step();
    end
    checkOutput("req_wait_expired", pma_rate_req, 1);
  endtask

  // Ack d cycles after the request is seen; completion is due SETTLE cycles
  // after the edge that samples the ack.
  task automatic finishChange(input logic [1:0] tgt, input int d);
    repeat (d) step();
    pma_rate_ack = 1'b1;
    pushDone(cyc + 1 + SETTLE, tgt, model_err);
    step();
    pma_rate_ack = 1'b0;
    checkOutput("dp_rate_after_ack", dp_pipe_rate, tgt);
    checkOutput("req_after_ack", pma_rate_req, 0);
    model_rate = tgt;
    repeat (SETTLE + 2) step();
    mac_tx_elec_idle = 1'b0;
  endtask

  task automatic applyStimulus(input logic [1:0] new_rate, input int idle_delay,
                               input int ack_delay, input bit timeout);
    logic [1:0] tgt;
    logic       dv;
    int         r;
    bit         ok;
    tgt = (new_rate == 2'b01) ? 2'b01 : 2'b00;
    dv  = 1'($urandom_range(0, 1));
    mac_tx_data_valid = dv;
    #1;
    checkOutput("dv_pass", dp_tx_data_valid, dv);
    mac_tx_data_valid = 1'b1;
    mac_rate = new_rate;
    mac_tx_elec_idle = (idle_delay == 0);
    #1;
    if (tgt == model_rate) begin
      checkOutput("dv_nochange", dp_tx_data_valid, 1);
      repeat (5) step();
      return;
    end
    checkOutput("dv_gated", dp_tx_data_valid, 0);
    if (idle_delay == 0) pushReq(cyc + 3, tgt);
    else begin
      for (int i = 0; i < idle_delay; i++) begin
        pma_rate_ack = (i == 0);
        step();
        checkOutput("req_quiesce", pma_rate_req, 0);
      end
      pma_rate_ack = 1'b0;
      mac_tx_elec_idle = 1'b1;
      pushReq(cyc + 2, tgt);
    end
    waitReq(r, ok);
    if (!ok) return;
    if (timeout) begin
      pushDone(r + ATO, model_rate, 1'b1);
      model_err = 1'b1;
      pushReq(r + ATO + 3, tgt);
      for (int i = 1; i <= ATO; i++) begin
        step();
        checkOutput("req_hold", pma_rate_req, (i < ATO));
      end
      waitReq(r, ok);
      if (!ok) return;
    end
    finishChange(tgt, ack_delay);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  r;
    bit  ok;
    logic [1:0] nr;
    repeat (3) step();
    checkOutput("rst_dp_rate", dp_pipe_rate, 0);
    checkOutput("rst_pma_rate", pma_rate, 0);
    checkOutput("rst_req", pma_rate_req, 0);
    checkOutput("rst_phy", pipe_phystatus, 0);
    checkOutput("rst_err", rate_chg_err, 0);
    checkOutput("rst_dv", dp_tx_data_valid, 1);

    // Change pending at reset release: first move on the second edge.
    mac_rate = 2'b01;
    mac_tx_elec_idle = 1'b1;
    step();
    pclk_rst_n = 1'b1;
    pushReq(cyc + 4, 2'b01);
    waitReq(r, ok);
    if (ok) finishChange(2'b01, 4);

    // Long quiesce hold, ack in the exact timeout cycle.
    applyStimulus(2'b00, 20, ATO - 1, 1'b0);
    // Reserved rate 11 while at 00: nothing happens.
    applyStimulus(2'b11, 0, 0, 1'b0);
    // Timeout then automatic retry.
    applyStimulus(2'b01, 0, 3, 1'b1);
    checkOutput("err_sticky", rate_chg_err, 1);

    for (int n = 0; n < 25; n++) begin
      nr = 2'($urandom_range(0, 3));
      applyStimulus(nr, ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(2, 6),
                    $urandom_range(0, ATO - 1), ($urandom_range(0, 4) == 0));
      step();
      pma_rate_ack = 1'b1;
      step();
      pma_rate_ack = 1'b0;
      step();
    end
    checkOutput("err_model", rate_chg_err, model_err);

    // Asynchronous reset while waiting for the ack.
    nr = (model_rate == 2'b01) ? 2'b00 : 2'b01;
    mac_rate = nr;
    mac_tx_elec_idle = 1'b1;
    pushReq(cyc + 3, nr);
    waitReq(r, ok);
    step();
    #2;
    pclk_rst_n = 1'b0;
    #1;
    checkOutput("async_rst_req", pma_rate_req, 0);
    checkOutput("async_rst_dp_rate", dp_pipe_rate, 0);
    checkOutput("async_rst_pma_rate", pma_rate, 0);
    checkOutput("async_rst_err", rate_chg_err, 0);
    checkOutput("async_rst_phy", pipe_phystatus, 0);
    mac_rate = 2'b00;
    mac_tx_elec_idle = 1'b0;
    model_rate = 2'b00;
    model_err = 1'b0;
    repeat (2) step();
    pclk_rst_n = 1'b1;
    repeat (10) step();
    checkOutput("post_rst_dp_rate", dp_pipe_rate, 0);
    checkOutput("post_rst_dv", dp_tx_data_valid, 1);

    checkOutput("req_q_drained", req_q.size(), 0);
    checkOutput("done_q_drained", done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
